// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single-port data memory between the CPU load/store path
//   (port 0) and the loader/debug master (port 1). At most one command is
//   issued per cycle. Reads are tracked through a fixed-latency return
//   pipeline, so each read result goes back to the port that issued it.
//
//   Optional feature (compile-time macro DMEM_ARB_RR_EN):
//     undefined : fixed priority, port 0 wins on contention; no pointer state.
//     defined   : round-robin on contention using a 1-bit preferred-port
//                 pointer. The pointer toggles after each contended grant.
//
// Parameters
//   AW        address width
//   DW        data width
//   READ_LAT  cycles from mem_read to valid mem_rdata (legal range 1..4)
//
// Ports
//   clk                 system clock, rising edge
//   reset               asynchronous, active-low reset
//   req0/req1           request valid, held with its fields until granted
//   we0/we1             1 = write, 0 = read
//   addr0/addr1         byte address
//   wdata0/wdata1       write data
//   gnt0/gnt1           command accepted this cycle (combinational)
//   rvalid0/rvalid1     read data valid for that port
//   rdata0/rdata1       read data, zero when the port's rvalid is low
//   mem_read/mem_write  memory strobes
//   mem_addr/mem_wdata  memory address / write data (hold value when idle)
//   mem_rdata           memory read data, valid READ_LAT cycles after mem_read
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int READ_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  // Return pipeline: bit i of each vector is stage i; a read enters stage 0
  // at the edge closing its grant cycle and is reported from the last stage,
  // which lines up with mem_rdata READ_LAT cycles after the command.
  logic [READ_LAT-1:0] pipe_valid_reg, pipe_valid_next;
  logic [READ_LAT-1:0] pipe_port_reg,  pipe_port_next;

  // Last issued address / write data, driven onto the memory pins when idle.
  logic [AW-1:0] addr_hold_reg,  addr_hold_next;
  logic [DW-1:0] wdata_hold_reg, wdata_hold_next;

`ifdef DMEM_ARB_RR_EN
  // Preferred port on contention: 0 = port 0, 1 = port 1.
  logic ptr_reg, ptr_next;
`endif

  logic gnt0_int, gnt1_int;
  logic issue_read;

  // ---------------------------------------------------------------------------
  // Grant selection. Gated by reset so nothing is granted while reset is low.
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt0_int = 1'b0;
    gnt1_int = 1'b0;
    if (reset) begin
`ifdef DMEM_ARB_RR_EN
      if (req0 && req1) begin
        gnt0_int = ~ptr_reg;
        gnt1_int = ptr_reg;
      end else begin
        gnt0_int = req0;
        gnt1_int = req1;
      end
`else
      gnt0_int = req0;
      gnt1_int = req1 & ~req0;
`endif
    end
  end

  assign issue_read = (gnt0_int & ~we0) | (gnt1_int & ~we1);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_valid_reg <= '0;
      pipe_port_reg  <= '0;
      addr_hold_reg  <= '0;
      wdata_hold_reg <= '0;
`ifdef DMEM_ARB_RR_EN
      ptr_reg        <= 1'b0;
`endif
    end else begin
      pipe_valid_reg <= pipe_valid_next;
      pipe_port_reg  <= pipe_port_next;
      addr_hold_reg  <= addr_hold_next;
      wdata_hold_reg <= wdata_hold_next;
`ifdef DMEM_ARB_RR_EN
      ptr_reg        <= ptr_next;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // Shift toward the output stage; stage 0 takes this cycle's read, if any.
    // Written as a shift so READ_LAT = 1 needs no special case.
    pipe_valid_next = (pipe_valid_reg << 1) | READ_LAT'(issue_read);
    pipe_port_next  = (pipe_port_reg << 1)  | READ_LAT'(gnt1_int);

    addr_hold_next  = addr_hold_reg;
    wdata_hold_next = wdata_hold_reg;
    if (gnt0_int) begin
      addr_hold_next  = addr0;
      wdata_hold_next = wdata0;
    end else if (gnt1_int) begin
      addr_hold_next  = addr1;
      wdata_hold_next = wdata1;
    end

`ifdef DMEM_ARB_RR_EN
    ptr_next = ptr_reg;
    // Only a contended cycle that actually granted moves the pointer.
    if (req0 && req1 && (gnt0_int || gnt1_int)) begin
      ptr_next = ~ptr_reg;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt0      = gnt0_int;
    gnt1      = gnt1_int;
    mem_read  = issue_read;
    mem_write = (gnt0_int & we0) | (gnt1_int & we1);
    // The hold-next value is the granted port's fields, or the held value
    // when idle, which is exactly what the pins must show.
    mem_addr  = addr_hold_next;
    mem_wdata = wdata_hold_next;

    // Decoded straight from the last pipeline flops; only one entry occupies
    // that stage, so at most one rvalid is high.
    rvalid0   = pipe_valid_reg[READ_LAT-1] & ~pipe_port_reg[READ_LAT-1];
    rvalid1   = pipe_valid_reg[READ_LAT-1] &  pipe_port_reg[READ_LAT-1];
    rdata0    = rvalid0 ? mem_rdata : '0;
    rdata1    = rvalid1 ? mem_rdata : '0;
  end

endmodule
